// File: rtl/axi_lite_intr_ctrl.sv
// -----------------------------------------------------------------------------
// axi_lite_intr_ctrl
//
// Purpose:
//   AXI4-Lite interrupt controller slave. It collects NUM_INTR interrupt
//   sources, and each source can be edge or level sensitive. Sources are
//   latched into a status register (ISR). The controller masks them per
//   source (IER) and globally (GIE), and drives one registered irq line.
//
// Register map (word offsets, decoded on address bits [4:2]):
//   0x00 GIE  bit0 global enable, RW
//   0x04 IER  per-source enable, RW
//   0x08 ISR  latched raw status, RO
//   0x0C IAR  write-1-to-clear ISR, reads 0
//   0x10 IPR  ISR & IER, RO
//   0x14 IMR  1 = edge, 0 = level, RW (reset value DEFAULT_MODE per bit)
//   0x18 ISET write-1-to-set ISR, reads 0 (only with INTR_SOFT_TRIGGER_EN)
//   Every other offset reads 0 and ignores writes. Responses are always OKAY.
//
// Optional build macro:
//   INTR_SOFT_TRIGGER_EN - enables the ISET register at offset 0x18.
//
// Ports:
//   ACLK, ARESETN        clock, synchronous active-low reset
//   S_AXI_AW*/W*/B*      AXI4-Lite write address / data / response channels
//   S_AXI_AR*/R*         AXI4-Lite read address / data channels
//   intr_in[NUM_INTR]    interrupt sources, synchronous to ACLK
//   irq                  combined interrupt request, registered
// -----------------------------------------------------------------------------
module axi_lite_intr_ctrl #(
    parameter int NUM_INTR           = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter bit IRQ_ACTIVE_LEVEL   = 1'b1,
    parameter bit DEFAULT_MODE       = 1'b0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    input  logic [NUM_INTR-1:0]           intr_in,
    output logic                          irq
);

    localparam logic [2:0] REG_GIE  = 3'd0;
    localparam logic [2:0] REG_IER  = 3'd1;
    localparam logic [2:0] REG_ISR  = 3'd2;
    localparam logic [2:0] REG_IAR  = 3'd3;
    localparam logic [2:0] REG_IPR  = 3'd4;
    localparam logic [2:0] REG_IMR  = 3'd5;
`ifdef INTR_SOFT_TRIGGER_EN
    localparam logic [2:0] REG_ISET = 3'd6;
`endif

    // AWREADY and WREADY always pulse together, so one register drives both.
    logic                wr_ready_q;
    logic                bvalid_q;
    logic                arready_q;
    logic                rvalid_q;
    logic [31:0]         rdata_q;

    logic                gie_q, gie_d;
    logic [NUM_INTR-1:0] ier_q, ier_d;
    logic [NUM_INTR-1:0] imr_q, imr_d;
    logic [NUM_INTR-1:0] isr_q, isr_d;
    logic [NUM_INTR-1:0] intr_q;
    logic [NUM_INTR-1:0] hw_set;
    logic [NUM_INTR-1:0] iar_clr;
`ifdef INTR_SOFT_TRIGGER_EN
    logic [NUM_INTR-1:0] sw_set;
`endif
    logic                irq_q, irq_d;

    logic [31:0]         wmask;
    logic [31:0]         wbits;
    logic [31:0]         rd_word;
    logic                wr_en;
    logic                rd_en;
    logic [2:0]          wr_idx;
    logic [2:0]          rd_idx;

    assign wmask  = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                     {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign wbits  = S_AXI_WDATA & wmask;
    assign wr_idx = S_AXI_AWADDR[4:2];
    assign rd_idx = S_AXI_ARADDR[4:2];
    assign wr_en  = wr_ready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_en  = arready_q & S_AXI_ARVALID & ~rvalid_q;

    // Protection bits, byte-lane address bits and the strobed bits above
    // NUM_INTR carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR, wbits, wmask};

    // ---------------- AXI handshakes ----------------
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            // The ~wr_ready_q term ends the ready pulse after one cycle. The
            // ~bvalid_q term holds off a queued write until B completes.
            wr_ready_q <= S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~wr_ready_q;
            if (wr_en)
                bvalid_q <= 1'b1;
            else if (S_AXI_BREADY)
                bvalid_q <= 1'b0;

            arready_q <= S_AXI_ARVALID & ~rvalid_q & ~arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_GIE: rd_word = {31'd0, gie_q};
            REG_IER: rd_word = 32'(ier_q);
            REG_ISR: rd_word = 32'(isr_q);
            REG_IPR: rd_word = 32'(isr_q & ier_q);
            REG_IMR: rd_word = 32'(imr_q);
            default: rd_word = '0;
        endcase
    end

    // ---------------- Capture ----------------
    // In edge mode a source sets its bit on a rising input. In level mode it
    // sets from the registered copy, which adds one cycle of latency.
    generate
        for (genvar gi = 0; gi < NUM_INTR; gi++) begin : g_capture
            assign hw_set[gi] = imr_q[gi] ? (intr_in[gi] & ~intr_q[gi]) : intr_q[gi];
        end
    endgenerate

    // ---------------- Register next state ----------------
    always_comb begin
        gie_d   = gie_q;
        ier_d   = ier_q;
        imr_d   = imr_q;
        iar_clr = '0;
`ifdef INTR_SOFT_TRIGGER_EN
        sw_set  = '0;
`endif
        if (wr_en) begin
            case (wr_idx)
                REG_GIE: if (S_AXI_WSTRB[0]) gie_d = S_AXI_WDATA[0];
                REG_IER: ier_d   = (ier_q & ~wmask[NUM_INTR-1:0]) | wbits[NUM_INTR-1:0];
                REG_IAR: iar_clr = wbits[NUM_INTR-1:0];
                REG_IMR: imr_d   = (imr_q & ~wmask[NUM_INTR-1:0]) | wbits[NUM_INTR-1:0];
`ifdef INTR_SOFT_TRIGGER_EN
                REG_ISET: sw_set = wbits[NUM_INTR-1:0];
`endif
                default: ;
            endcase
        end
        // Set sources are ORed in after the clear, so a set wins over an
        // acknowledge of the same bit in the same cycle.
`ifdef INTR_SOFT_TRIGGER_EN
        isr_d = (isr_q & ~iar_clr) | hw_set | sw_set;
`else
        isr_d = (isr_q & ~iar_clr) | hw_set;
`endif
        irq_d = (gie_q & |(isr_q & ier_q)) ? IRQ_ACTIVE_LEVEL : ~IRQ_ACTIVE_LEVEL;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            gie_q  <= 1'b0;
            ier_q  <= '0;
            imr_q  <= {NUM_INTR{DEFAULT_MODE}};
            isr_q  <= '0;
            intr_q <= '0;
            irq_q  <= ~IRQ_ACTIVE_LEVEL;
        end else begin
            gie_q  <= gie_d;
            ier_q  <= ier_d;
            imr_q  <= imr_d;
            isr_q  <= isr_d;
            intr_q <= intr_in;
            irq_q  <= irq_d;
        end
    end

    assign S_AXI_AWREADY = wr_ready_q;
    assign S_AXI_WREADY  = wr_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign irq           = irq_q;

endmodule

// File: tb/tb_axi_lite_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_intr_ctrl
//
// Directed bench for axi_lite_intr_ctrl with its default parameters
// (NUM_INTR=8, active-high irq, level mode after reset). A register-level
// model tracks GIE/IER/IMR/ISR and the expected irq. irq is compared against
// the model on every cycle. Each read is compared against both the model and
// a hand-computed literal.
// -----------------------------------------------------------------------------
module tb_axi_lite_intr_ctrl;

    localparam int N       = 8;
    localparam bit L       = 1'b1;
    localparam bit DM      = 1'b0;
    localparam int TIMEOUT = 50;

    localparam logic [4:0] A_GIE = 5'h00, A_IER = 5'h04, A_ISR = 5'h08, A_IAR = 5'h0C;
    localparam logic [4:0] A_IPR = 5'h10, A_IMR = 5'h14, A_ISET = 5'h18, A_UNM = 5'h1C;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [N-1:0] intr_in;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state, updated once per rising edge.
    logic         m_gie;
    logic [N-1:0] m_ier, m_imr, m_isr, m_prev;
    logic         m_irq;
    // A write the bench has handed to the DUT. It lands on the next rising edge.
    logic         pend_wr = 1'b0;
    logic [4:0]   pend_addr;
    logic [31:0]  pend_data;
    logic [3:0]   pend_strb;

    always #5 clk = ~clk;

    axi_lite_intr_ctrl #(
        .NUM_INTR(N), .C_S_AXI_ADDR_WIDTH(5), .IRQ_ACTIVE_LEVEL(L), .DEFAULT_MODE(DM)
    ) dut (
        .ACLK(clk), .ARESETN(rstn),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .intr_in(intr_in), .irq(irq)
    );

    // ---------------- Model ----------------
    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            A_GIE:   return {31'd0, m_gie};
            A_IER:   return {24'd0, m_ier};
            A_ISR:   return {24'd0, m_isr};
            A_IPR:   return {24'd0, m_isr & m_ier};
            A_IMR:   return {24'd0, m_imr};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic [N-1:0] setb, clr, sw;
        logic [31:0]  bm, d;
        logic         nxt_irq;
        if (!rstn) begin
            m_gie = 1'b0; m_ier = '0; m_isr = '0; m_prev = '0;
            m_imr = {N{DM}}; m_irq = ~L; pend_wr = 1'b0;
            return;
        end
        // irq reflects the pending state seen before this edge.
        nxt_irq = (m_gie && ((m_isr & m_ier) != 0)) ? L : ~L;
        // Sources use the mode that was in force before this edge.
        setb = '0;
        for (int i = 0; i < N; i++)
            setb[i] = m_imr[i] ? (intr_in[i] && !m_prev[i]) : m_prev[i];
        clr = '0;
        sw  = '0;
        if (pend_wr) begin
            bm = '0;
            for (int b = 0; b < 4; b++)
                if (pend_strb[b]) bm[b*8 +: 8] = 8'hFF;
            d = pend_data & bm;
            case (pend_addr)
                A_GIE: if (pend_strb[0]) m_gie = pend_data[0];
                A_IER: m_ier = (m_ier & ~bm[N-1:0]) | d[N-1:0];
                A_IAR: clr = d[N-1:0];
                A_IMR: m_imr = (m_imr & ~bm[N-1:0]) | d[N-1:0];
`ifdef INTR_SOFT_TRIGGER_EN
                A_ISET: sw = d[N-1:0];
`endif
                default: ;
            endcase
            pend_wr = 1'b0;
        end
        m_isr  = (m_isr & ~clr) | setb | sw;
        m_prev = intr_in;
        m_irq  = nxt_irq;
    endtask

    always @(posedge clk) model_step();

    // Checks irq against the model on every cycle after the first reset edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_tests++;
                if (irq !== m_irq) begin
                    n_fail++;
                    $display("FAIL irq_cycle @%0t: got %b, expected %b", $time, irq, m_irq);
                end
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_awready(output bit ok);
        int n = 0;
        while (awready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        ok = (awready === 1'b1);
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL awready_timeout: got 0, expected 1 within %0d cycles", TIMEOUT);
        end
    endtask

    task automatic note_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        pend_addr = a; pend_data = d; pend_strb = s; pend_wr = 1'b1;
    endtask

    // Full write. pulse_hs raises intr_in bits for exactly the handshake cycle.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [N-1:0] pulse_hs);
        bit ok;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        wait_awready(ok);
        if (!ok) begin
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        check("wready_with_awready", {31'd0, wready}, 32'd1);
        intr_in = intr_in | pulse_hs;
        note_write(a, d, s);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        intr_in = intr_in & ~pulse_hs;
        check("bvalid_after_write", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, 32'd0);
        $display("[TB] write addr 0x%02h data 0x%08h strb %b", a, d, s);
    endtask

    task automatic axi_read(input logic [4:0] a, input logic [31:0] lit, input string name);
        logic [31:0] exp_m;
        int n = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        while (arready !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (arready !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s arready_timeout: got 0, expected 1", name);
            arvalid = 1'b0;
            return;
        end
        exp_m = model_read(a);
        @(negedge clk);
        arvalid = 1'b0;
        check({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check({name, "_model"}, rdata, exp_m);
        check(name, rdata, lit);
        check({name, "_rresp"}, {30'd0, rresp}, 32'd0);
        $display("[TB] read addr 0x%02h data 0x%08h (%s)", a, rdata, name);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        @(negedge clk);
        intr_in = intr_in | m;
        @(negedge clk);
        intr_in = intr_in & ~m;
    endtask

    // Register-access patterns and the values each register must read back.
    logic [31:0] pat     [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
    logic [31:0] exp_gie [4] = '{32'h1, 32'h1, 32'h1, 32'h1};
    logic [31:0] exp_8b  [4] = '{32'hFF, 32'h01, 32'h11, 32'h11};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rstn = 1'b0; awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; arvalid = 1'b0; rready = 1'b1;
        wdata = '0; wstrb = '0; intr_in = '0;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        check("rst_irq",     {31'd0, irq}, {31'd0, ~L});
        rstn = 1'b1;
        axi_read(A_IMR, 32'h00, "rst_imr");
        axi_read(A_GIE, 32'h00, "rst_gie");

        // ---- Register access ----
        for (int k = 0; k < 4; k++) begin
            axi_write(A_GIE, pat[k], 4'hF, '0);
            axi_write(A_IER, pat[k], 4'hF, '0);
            axi_write(A_IMR, pat[k], 4'hF, '0);
            axi_read(A_GIE, exp_gie[k], "rw_gie");
            axi_read(A_IER, exp_8b[k],  "rw_ier");
            axi_read(A_IMR, exp_8b[k],  "rw_imr");
        end
        axi_write(A_IER, 32'h0000005A, 4'b0001, '0);
        axi_read(A_IER, 32'h5A, "strb_byte0");
        axi_write(A_IER, 32'hFFFFFFFF, 4'b0000, '0);
        axi_read(A_IER, 32'h5A, "strb_none");
        axi_write(A_IER, 32'h000000FF, 4'b1110, '0);
        axi_read(A_IER, 32'h5A, "strb_upper_only");
        axi_write(A_ISR, 32'hFF, 4'hF, '0);
        axi_read(A_ISR, 32'h00, "isr_ro");
        axi_read(A_UNM, 32'h00, "unmapped_rd");
        axi_read(A_IAR, 32'h00, "iar_reads0");
        axi_write(A_ISET, 32'h81, 4'hF, '0);
        axi_read(A_ISET, 32'h00, "iset_reads0");
`ifdef INTR_SOFT_TRIGGER_EN
        axi_read(A_ISR, 32'h81, "iset_sets_isr");
`else
        axi_read(A_ISR, 32'h00, "iset_unmapped");
`endif
        axi_write(A_GIE, 32'h0, 4'hF, '0);
        axi_write(A_IAR, 32'hFF, 4'hF, '0);

        // ---- Edge mode ----
        axi_write(A_IMR, 32'hFF, 4'hF, '0);
        axi_write(A_IER, 32'h04, 4'hF, '0);
        axi_write(A_GIE, 32'h01, 4'hF, '0);
        @(negedge clk); intr_in = 8'h04;
        @(negedge clk); intr_in = 8'h00;
        check("edge_irq_before_E1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("edge_irq_at_E1", {31'd0, irq}, 32'd1);
        axi_read(A_ISR, 32'h04, "edge_isr");
        axi_read(A_IPR, 32'h04, "edge_ipr");
        axi_write(A_IAR, 32'h04, 4'hF, '0);
        axi_read(A_IPR, 32'h00, "edge_ipr_acked");
        check("edge_irq_acked", {31'd0, irq}, 32'd0);

        // ---- Level re-trigger ----
        axi_write(A_GIE, 32'h0, 4'hF, '0);
        axi_write(A_IMR, 32'h00, 4'hF, '0);
        axi_write(A_IER, 32'h01, 4'hF, '0);
        axi_write(A_GIE, 32'h1, 4'hF, '0);
        @(negedge clk); intr_in = 8'h01;
        repeat (3) @(negedge clk);
        check("level_irq_E2", {31'd0, irq}, 32'd1);
        axi_write(A_IAR, 32'h01, 4'hF, '0);
        axi_read(A_ISR, 32'h01, "level_isr_retrig");
        check("level_irq_held", {31'd0, irq}, 32'd1);
        intr_in = 8'h00;
        repeat (2) @(negedge clk);
        axi_write(A_IAR, 32'h01, 4'hF, '0);
        repeat (2) @(negedge clk);
        check("level_irq_released", {31'd0, irq}, 32'd0);
        axi_read(A_ISR, 32'h00, "level_isr_released");

        // ---- Masking ----
        axi_write(A_GIE, 32'h0, 4'hF, '0);
        axi_write(A_IMR, 32'hFF, 4'hF, '0);
        axi_write(A_IER, 32'h00, 4'hF, '0);
        axi_write(A_GIE, 32'h1, 4'hF, '0);
        pulse(8'h20);
        repeat (2) @(negedge clk);
        axi_read(A_ISR, 32'h20, "mask_isr");
        axi_read(A_IPR, 32'h00, "mask_ipr");
        check("mask_irq_ier0", {31'd0, irq}, 32'd0);
        axi_write(A_GIE, 32'h0, 4'hF, '0);
        axi_write(A_IER, 32'h20, 4'hF, '0);
        repeat (2) @(negedge clk);
        check("mask_irq_gie0", {31'd0, irq}, 32'd0);
        axi_write(A_GIE, 32'h1, 4'hF, '0);
        check("mask_irq_not_yet", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("mask_irq_gie1", {31'd0, irq}, 32'd1);
        axi_write(A_GIE, 32'h0, 4'hF, '0);
        repeat (2) @(negedge clk);
        check("mask_irq_gie_off", {31'd0, irq}, 32'd0);
        axi_read(A_ISR, 32'h20, "mask_isr_preserved");
        axi_write(A_IAR, 32'h20, 4'hF, '0);

        // ---- Collision ----
        axi_write(A_IER, 32'h08, 4'hF, '0);
        axi_write(A_GIE, 32'h1, 4'hF, '0);
        pulse(8'h08);
        repeat (2) @(negedge clk);
        check("coll_irq_set", {31'd0, irq}, 32'd1);
        axi_write(A_IAR, 32'h08, 4'hF, 8'h08);
        axi_read(A_ISR, 32'h08, "coll_set_wins");
        check("coll_irq_held", {31'd0, irq}, 32'd1);
        axi_write(A_IAR, 32'h08, 4'hF, '0);
        repeat (2) @(negedge clk);
        check("coll_irq_acked", {31'd0, irq}, 32'd0);
        axi_read(A_ISR, 32'h00, "coll_isr_acked");

        // ---- Write backpressure ----
        @(negedge clk);
        awaddr = A_IER; wdata = 32'h0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        wait_awready(ok);
        if (ok) note_write(A_IER, 32'h0F, 4'hF);
        @(negedge clk);
        wdata = 32'h3C;   // second write queued behind the unacknowledged B
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid_held", {31'd0, bvalid}, 32'd1);
            check("bp_awready_low", {31'd0, awready}, 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        check("bp_bvalid_cleared", {31'd0, bvalid}, 32'd0);
        wait_awready(ok);
        if (ok) note_write(A_IER, 32'h3C, 4'hF);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_second_bvalid", {31'd0, bvalid}, 32'd1);
        $display("[TB] queued write addr 0x%02h data 0x%08h after backpressure", A_IER, 32'h3C);
        axi_read(A_IER, 32'h3C, "bp_ier");

        // ---- Reset mid-read ----
        axi_write(A_IER, 32'h01, 4'hF, '0);
        pulse(8'h01);
        repeat (2) @(negedge clk);
        check("rst_pre_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        araddr = A_IMR; arvalid = 1'b1; rready = 1'b0;
        for (int c = 0; c < TIMEOUT && arready !== 1'b1; c++) @(negedge clk);
        check("midrd_arready", {31'd0, arready}, 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("midrd_rvalid", {31'd0, rvalid}, 32'd1);
        check("midrd_rdata", rdata, 32'hFF);
        @(negedge clk);
        check("midrd_rvalid_hold", {31'd0, rvalid}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrd_rvalid_rst", {31'd0, rvalid}, 32'd0);
        check("midrd_irq_rst", {31'd0, irq}, {31'd0, ~L});
        check("midrd_arready_rst", {31'd0, arready}, 32'd0);
        check("midrd_bvalid_rst", {31'd0, bvalid}, 32'd0);
        $display("[TB] reset asserted during read, response dropped");
        rready = 1'b1;
        rstn = 1'b1;
        axi_read(A_IMR, {24'd0, {N{DM}}}, "midrd_imr_default");
        axi_read(A_ISR, 32'h00, "midrd_isr");
        axi_read(A_IER, 32'h00, "midrd_ier");
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
